// File: rtl/ghadi_set_controller.sv
// Button-driven set/arm sequencer for the Aclock alarm clock: digit editing with
// one-cycle time/alarm commits, alarm arm level, snooze and ring auto-stop.
module ghadi_set_controller #(
    parameter int EDIT_TIMEOUT = 30,
    parameter int ALARM_MAX    = 60
) (
    input  logic       Ghadi,
    input  logic       Reset,
    input  logic       Btn_Samay,
    input  logic       Btn_AlarmSet,
    input  logic       Btn_Next,
    input  logic       Btn_Inc,
    input  logic       Btn_Arm,
    input  logic       Btn_Snooze,
    input  logic       Alarm,
    input  logic [1:0] Hours_Ki_Tenth_digit_CUR,
    input  logic [3:0] Hours_Ki_Ones_digit_CUR,
    input  logic [3:0] Mins_Ki_Tenth_digit_CUR,
    input  logic [3:0] Mins_Ki_Ones_digit_CUR,
    output logic [1:0] Hours_Ki_Tenth_digit_IN,
    output logic [3:0] Hours_Ki_Ones_digit_IN,
    output logic [3:0] Mins_Ki_Tenth_digit_IN,
    output logic [3:0] Mins_Ki_Ones_digit_IN,
    output logic       Load_Samay,
    output logic       Load_Alarm,
    output logic       Alarm_Chalu,
    output logic       Alarm_Band,
    output logic [2:0] Edit_Sel
);

    typedef enum logic [3:0] {
        IDLE, T_HT, T_HO, T_MT, T_MO, T_COMMIT,
        A_HT, A_HO, A_MT, A_MO, A_COMMIT
    } state_t;

    localparam int TW = $clog2(EDIT_TIMEOUT + 1);
    localparam int RW = $clog2(ALARM_MAX + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(EDIT_TIMEOUT - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(ALARM_MAX - 1);

    state_t        state, state_n;
    logic [5:0]    btn, btn_prev, btn_edge;
    logic          e_samay, e_aset, e_next, e_inc, e_arm, e_snooze, any_edge;
    logic [1:0]    ht, sh_ht, ht_inc;
    logic [3:0]    ho, mt, mo, sh_ho, sh_mt, sh_mo;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] ring_cnt;
    logic          to_expired;

    assign btn      = {Btn_Snooze, Btn_Arm, Btn_Inc, Btn_Next, Btn_AlarmSet, Btn_Samay};
    assign btn_edge = btn & ~btn_prev;
    assign {e_snooze, e_arm, e_inc, e_next, e_aset, e_samay} = btn_edge;
    assign any_edge   = |btn_edge;
    assign to_expired = (to_cnt == TO_LAST) && !any_edge;
    assign ht_inc     = (ht == 2'd2) ? 2'd0 : ht + 2'd1;

    assign Hours_Ki_Tenth_digit_IN = ht;
    assign Hours_Ki_Ones_digit_IN  = ho;
    assign Mins_Ki_Tenth_digit_IN  = mt;
    assign Mins_Ki_Ones_digit_IN   = mo;

    // NOTE: state and every register below use non-blocking assignments so all
    // flops update together from the same pre-edge values.
    always_ff @(posedge Ghadi) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    // NOTE: every always_comb output gets a default first, otherwise a missed
    // branch would infer a latch.
    always_comb begin
        state_n    = state;
        Edit_Sel   = 3'd0;
        Load_Samay = 1'b0;
        Load_Alarm = 1'b0;
        unique case (state)
            IDLE:     if (e_samay) state_n = T_HT;
                      else if (e_aset) state_n = A_HT;
            T_HT:     begin Edit_Sel = 3'd1; if (e_next) state_n = T_HO;     end
            T_HO:     begin Edit_Sel = 3'd2; if (e_next) state_n = T_MT;     end
            T_MT:     begin Edit_Sel = 3'd3; if (e_next) state_n = T_MO;     end
            T_MO:     begin Edit_Sel = 3'd4; if (e_next) state_n = T_COMMIT; end
            A_HT:     begin Edit_Sel = 3'd1; if (e_next) state_n = A_HO;     end
            A_HO:     begin Edit_Sel = 3'd2; if (e_next) state_n = A_MT;     end
            A_MT:     begin Edit_Sel = 3'd3; if (e_next) state_n = A_MO;     end
            A_MO:     begin Edit_Sel = 3'd4; if (e_next) state_n = A_COMMIT; end
            T_COMMIT: begin Load_Samay = 1'b1; state_n = IDLE; end
            A_COMMIT: begin Load_Alarm = 1'b1; state_n = IDLE; end
            default:  state_n = IDLE;
        endcase
        if (Edit_Sel != 3'd0 && to_expired) state_n = IDLE;
    end

    // Edit registers; Edit_Sel doubles as the selected-digit index (0 in IDLE/COMMIT).
    always_ff @(posedge Ghadi) begin
        if (Reset) begin
            {ht, ho, mt, mo}             <= '0;
            {sh_ht, sh_ho, sh_mt, sh_mo} <= '0;
        end else begin
            if (state == IDLE && e_samay) begin
                ht <= Hours_Ki_Tenth_digit_CUR;
                ho <= Hours_Ki_Ones_digit_CUR;
                mt <= Mins_Ki_Tenth_digit_CUR;
                mo <= Mins_Ki_Ones_digit_CUR;
            end else if (state == IDLE && e_aset) begin
                {ht, ho, mt, mo} <= {sh_ht, sh_ho, sh_mt, sh_mo};
            end else if (e_inc) begin
                unique case (Edit_Sel)
                    3'd1: begin
                        ht <= ht_inc;
                        if (ht_inc == 2'd2 && ho > 4'd3) ho <= 4'd3;
                    end
                    3'd2: ho <= ((ht == 2'd2 && ho >= 4'd3) || ho >= 4'd9) ? 4'd0 : ho + 4'd1;
                    3'd3: mt <= (mt >= 4'd5) ? 4'd0 : mt + 4'd1;
                    3'd4: mo <= (mo >= 4'd9) ? 4'd0 : mo + 4'd1;
                    default: ;
                endcase
            end
            if (state == A_COMMIT) {sh_ht, sh_ho, sh_mt, sh_mo} <= {ht, ho, mt, mo};
        end
    end

    // Edit inactivity timer: held at zero outside edit states, restarted by any edge.
    always_ff @(posedge Ghadi) begin
        if (Reset || Edit_Sel == 3'd0 || any_edge || to_cnt == TO_LAST) to_cnt <= '0;
        else                                                           to_cnt <= to_cnt + 1'b1;
    end

    // Arm, snooze and ring auto-stop run regardless of the edit state.
    always_ff @(posedge Ghadi) begin
        if (Reset) begin
            btn_prev    <= '0;
            Alarm_Chalu <= 1'b0;
            Alarm_Band  <= 1'b0;
            ring_cnt    <= '0;
        end else begin
            btn_prev   <= btn;
            Alarm_Band <= Alarm && (e_snooze || ring_cnt == RING_LAST || (e_arm && Alarm_Chalu));
            if (e_arm) Alarm_Chalu <= ~Alarm_Chalu;
            if (!Alarm || ring_cnt == RING_LAST) ring_cnt <= '0;
            else                                 ring_cnt <= ring_cnt + 1'b1;
        end
    end

endmodule
